// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the multi-channel LED driver: mode codes,
// configuration word layout and breathe ramp direction.
package led_ctrl_pkg;

  localparam logic [2:0] MODE_OFF     = 3'd0;
  localparam logic [2:0] MODE_ON      = 3'd1;
  localparam logic [2:0] MODE_BLINK   = 3'd2;
  localparam logic [2:0] MODE_PWM     = 3'd3;
  localparam logic [2:0] MODE_GPIO    = 3'd4;
  localparam logic [2:0] MODE_BREATHE = 3'd5;

  localparam int unsigned CFG_MODE_LSB = 0;
  localparam int unsigned CFG_MODE_W   = 3;
  localparam int unsigned CFG_IDX_LSB  = 3;
  localparam int unsigned CFG_IDX_W    = 5;
  localparam int unsigned CFG_DUTY_LSB = 8;
  localparam int unsigned CFG_DUTY_W   = 8;

  typedef enum logic [0:0] {
    BR_UP   = 1'b0,
    BR_DOWN = 1'b1
  } breathe_state_e;

  typedef struct packed {
    logic [CFG_MODE_W-1:0] mode;
    logic [CFG_IDX_W-1:0]  idx;
    logic [CFG_DUTY_W-1:0] duty;
  } cfg_fields_t;

  // Only the low half of the config word carries fields.
  function automatic cfg_fields_t cfg_unpack(input logic [15:0] w);
    cfg_fields_t f;
    f.mode = w[CFG_MODE_LSB +: CFG_MODE_W];
    f.idx  = w[CFG_IDX_LSB +: CFG_IDX_W];
    f.duty = w[CFG_DUTY_LSB +: CFG_DUTY_W];
    return f;
  endfunction

endpackage

// File: rtl/led_chan.sv
// One LED channel: config registers, GPIO hold, breathe ramp and the
// registered output driven from the shared free-running counter.
module led_chan
  import led_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W         = 25,
  parameter int unsigned PWM_W         = 8,
  parameter int unsigned STEP_BIT      = 16,
  parameter logic [2:0]  RST_MODE      = MODE_GPIO,
  parameter int unsigned RST_BLINK_IDX = 22
) (
  input  logic             clk_25m_i,
  input  logic             sys_rstn_i,
  input  logic             we_i,
  input  cfg_fields_t      cfg_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             gpio_out_i,
  input  logic             gpio_oe_n_i,
  output logic             led_o
);

  localparam logic [4:0]       IDX_MAX  = 5'(CNT_W - 1);
  localparam logic [PWM_W-1:0] DUTY_ONE = PWM_W'(1);
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;
  localparam logic [PWM_W-1:0] DUTY_PEN = DUTY_MAX - DUTY_ONE;

  logic [2:0]       mode_q, mode_d;
  logic [4:0]       idx_q, idx_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic [PWM_W-1:0] bduty_q, bduty_d;
  breathe_state_e   bstate_q, bstate_d;
  logic             hold_q, hold_d;
  logic             led_q, led_d;

  logic             step;
  logic [31:0]      cnt_ext;
  logic [PWM_W-1:0] phase;

  assign step    = (cnt_i[STEP_BIT-1:0] == '0);
  assign cnt_ext = 32'(cnt_i);
  assign phase   = cnt_i[PWM_W-1:0];

  always_comb begin
    mode_d   = mode_q;
    idx_d    = idx_q;
    duty_d   = duty_q;
    bduty_d  = bduty_q;
    bstate_d = bstate_q;
    hold_d   = gpio_oe_n_i ? hold_q : gpio_out_i;

    // Ramp turns around on the step that reaches an extreme, so the
    // extreme value is held for exactly one step period.
    if (mode_q == MODE_BREATHE && step) begin
      case (bstate_q)
        BR_UP: begin
          if (bduty_q != DUTY_MAX) bduty_d = bduty_q + DUTY_ONE;
          if (bduty_q == DUTY_PEN || bduty_q == DUTY_MAX) bstate_d = BR_DOWN;
        end
        BR_DOWN: begin
          if (bduty_q != '0) bduty_d = bduty_q - DUTY_ONE;
          if (bduty_q == DUTY_ONE || bduty_q == '0) bstate_d = BR_UP;
        end
        default: bstate_d = BR_UP;
      endcase
    end

    // A write overrides any concurrent ramp step.
    if (we_i) begin
      mode_d = cfg_i.mode;
      idx_d  = (cfg_i.idx > IDX_MAX) ? IDX_MAX : cfg_i.idx;
      duty_d = cfg_i.duty[PWM_W-1:0];
      if (cfg_i.mode == MODE_BREATHE) begin
        bduty_d  = '0;
        bstate_d = BR_UP;
      end
    end
  end

  always_comb begin
    case (mode_q)
      MODE_ON:      led_d = 1'b1;
      MODE_BLINK:   led_d = cnt_ext[idx_q];
      MODE_PWM:     led_d = (phase < duty_q);
      MODE_GPIO:    led_d = hold_q;
      MODE_BREATHE: led_d = (phase < bduty_q);
      default:      led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_25m_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      mode_q   <= RST_MODE;
      idx_q    <= 5'(RST_BLINK_IDX);
      duty_q   <= '0;
      bduty_q  <= '0;
      bstate_q <= BR_UP;
      hold_q   <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      idx_q    <= idx_d;
      duty_q   <= duty_d;
      bduty_q  <= bduty_d;
      bstate_q <= bstate_d;
      hold_q   <= hold_d;
      led_q    <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_ctrl.sv
// Multi-channel LED driver: shared free-running counter with wrap tick,
// config write decode and one led_chan per output.
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LED       = 4,
  parameter int unsigned CNT_W         = 25,
  parameter int unsigned PWM_W         = 8,
  parameter int unsigned STEP_BIT      = 16,
  parameter logic [2:0]  RST_MODE      = MODE_GPIO,
  parameter int unsigned RST_BLINK_IDX = 22
) (
  input  logic               clk_25m,
  input  logic               sys_rstn,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  input  logic [NUM_LED-1:0] gpio_out,
  input  logic [NUM_LED-1:0] gpio_oe_n,
  output logic [NUM_LED-1:0] led,
  output logic               hb_tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             hb_tick_q;
  cfg_fields_t      cfg_fields;
  logic             unused_cfg_hi;

  assign cnt_d         = cnt_q + CNT_W'(1);
  assign wrap_d        = &cnt_q;
  assign cfg_fields    = cfg_unpack(cfg_wdata[15:0]);
  assign unused_cfg_hi = ^cfg_wdata[31:16];

  // wrap_q marks the cycle the counter sits at 0 after a wrap; the tick
  // follows one cycle later, so reset itself never produces a tick.
  always_ff @(posedge clk_25m or negedge sys_rstn) begin
    if (!sys_rstn) begin
      cnt_q     <= '0;
      wrap_q    <= 1'b0;
      hb_tick_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wrap_q    <= wrap_d;
      hb_tick_q <= wrap_q;
    end
  end

  assign hb_tick = hb_tick_q;

  for (genvar gi = 0; gi < NUM_LED; gi++) begin : g_chan
    logic chan_we;
    assign chan_we = cfg_we && (cfg_addr == 4'(gi));

    led_chan #(
      .CNT_W         (CNT_W),
      .PWM_W         (PWM_W),
      .STEP_BIT      (STEP_BIT),
      .RST_MODE      (RST_MODE),
      .RST_BLINK_IDX (RST_BLINK_IDX)
    ) u_chan (
      .clk_25m_i   (clk_25m),
      .sys_rstn_i  (sys_rstn),
      .we_i        (chan_we),
      .cfg_i       (cfg_fields),
      .cnt_i       (cnt_q),
      .gpio_out_i  (gpio_out[gi]),
      .gpio_oe_n_i (gpio_oe_n[gi]),
      .led_o       (led[gi])
    );
  end

endmodule

// File: tb/tb_led_ctrl.sv
// Bench for led_ctrl: default-parameter instance plus a small instance
// (CNT_W=5, PWM_W=4, STEP_BIT=4) for wrap tick and breathe ramp checks.
module tb_led_ctrl;

  logic        clk_25m = 1'b0;
  logic        sys_rstn = 1'b0;
  logic        cfg_we_a = 1'b0;
  logic        cfg_we_b = 1'b0;
  logic [3:0]  cfg_addr = 4'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic [3:0]  gpio_out = 4'hF;
  logic [3:0]  gpio_oe_n = 4'hF;
  logic [3:0]  led_a, led_b;
  logic        hb_a, hb_b;

  int checks = 0;
  int failures = 0;
  int unsigned edges;

  always #5 clk_25m = ~clk_25m;

  // Cycles since reset release; equals the DUT counter value (mod 2^CNT_W).
  always @(posedge clk_25m or negedge sys_rstn)
    if (!sys_rstn) edges <= 0;
    else edges <= edges + 1;

  led_ctrl dut_a (
    .clk_25m(clk_25m), .sys_rstn(sys_rstn), .cfg_we(cfg_we_a),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .gpio_out(gpio_out),
    .gpio_oe_n(gpio_oe_n), .led(led_a), .hb_tick(hb_a)
  );

  led_ctrl #(.NUM_LED(4), .CNT_W(5), .PWM_W(4), .STEP_BIT(4)) dut_b (
    .clk_25m(clk_25m), .sys_rstn(sys_rstn), .cfg_we(cfg_we_b),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .gpio_out(gpio_out),
    .gpio_oe_n(gpio_oe_n), .led(led_b), .hb_tick(hb_b)
  );

  typedef struct {
    bit         sel;
    logic [3:0] addr;
    logic [2:0] mode;
    logic [4:0] idx;
    logic [7:0] duty;
    int         ch;
    int         exp_high;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];
  int   sb[$];
  bit   bq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cfg_write(input bit sel, input logic [3:0] addr, input logic [2:0] mode,
                           input logic [4:0] idx, input logic [7:0] duty);
    cfg_addr  = addr;
    cfg_wdata = {16'hA5C3, duty, idx, mode};
    if (sel) cfg_we_b = 1'b1;
    else cfg_we_a = 1'b1;
    @(negedge clk_25m);
    cfg_we_a = 1'b0;
    cfg_we_b = 1'b0;
  endtask

  function automatic logic [3:0] led_of(input bit sel);
    return sel ? led_b : led_a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, exp, pulses, bd;
    bit up, rewritten;
    logic [3:0] l;
    int unsigned c;

    vecs[0]  = '{1'b0, 4'd0, 3'd3, 5'd0,  8'd64,  0, 64};
    vecs[1]  = '{1'b0, 4'd0, 3'd3, 5'd0,  8'd0,   0, 0};
    vecs[2]  = '{1'b0, 4'd0, 3'd3, 5'd0,  8'd255, 0, 255};
    vecs[3]  = '{1'b0, 4'd0, 3'd3, 5'd0,  8'd1,   0, 1};
    vecs[4]  = '{1'b0, 4'd1, 3'd1, 5'd0,  8'd0,   1, 256};
    vecs[5]  = '{1'b0, 4'd1, 3'd0, 5'd0,  8'd0,   1, 0};
    vecs[6]  = '{1'b0, 4'd2, 3'd2, 5'd3,  8'd0,   2, 128};
    vecs[7]  = '{1'b0, 4'd2, 3'd2, 5'd7,  8'd0,   2, 128};
    vecs[8]  = '{1'b0, 4'd3, 3'd6, 5'd0,  8'd0,   3, 0};
    vecs[9]  = '{1'b0, 4'd3, 3'd7, 5'd0,  8'd0,   3, 0};
    vecs[10] = '{1'b1, 4'd1, 3'd3, 5'd0,  8'h35,  1, 80};
    vecs[11] = '{1'b1, 4'd2, 3'd2, 5'd31, 8'd0,   2, 128};
    vecs[12] = '{1'b1, 4'd2, 3'd2, 5'd24, 8'd0,   2, 128};
    vecs[13] = '{1'b1, 4'd3, 3'd3, 5'd0,  8'h0F,  3, 240};

    // Reset state and idle behaviour
    repeat (3) @(negedge clk_25m);
    chk("rst_led_a", int'(led_a), 0);
    chk("rst_hb_a", int'(hb_a), 0);
    chk("rst_led_b", int'(led_b), 0);
    sys_rstn = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_25m);
      chk("idle_led_a", int'(led_a), 0);
      chk("idle_hb_a", int'(hb_a), 0);
    end

    // GPIO follow and hold
    gpio_out  = 4'b0010;
    gpio_oe_n = 4'b1101;
    @(negedge clk_25m);
    chk("gpio_lat1", int'(led_a[1]), 0);
    @(negedge clk_25m);
    chk("gpio_lat2", int'(led_a[1]), 1);
    gpio_oe_n = 4'hF;
    gpio_out  = 4'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_25m);
      chk("gpio_hold", int'(led_a[1]), 1);
    end

    // Config write reaches led on the second edge
    cfg_write(1'b0, 4'd3, 3'd1, 5'd0, 8'd0);
    chk("wr_lat1", int'(led_a[3]), 0);
    @(negedge clk_25m);
    chk("wr_lat2", int'(led_a[3]), 1);

    // Table-driven duty / blink / mode vectors: high cycles over 256 cycles
    for (int v = 0; v < NV; v++) begin
      cfg_write(vecs[v].sel, vecs[v].addr, vecs[v].mode, vecs[v].idx, vecs[v].duty);
      sb.push_back(vecs[v].exp_high);
      @(negedge clk_25m);
      hi = 0;
      for (int k = 0; k < 256; k++) begin
        @(negedge clk_25m);
        l = led_of(vecs[v].sel);
        hi += int'(l[vecs[v].ch]);
      end
      exp = sb.pop_front();
      chk($sformatf("vec%0d_high", v), hi, exp);
    end

    // Blink follows cnt[3] delayed by one cycle
    cfg_write(1'b0, 4'd2, 3'd2, 5'd3, 8'd0);
    @(negedge clk_25m);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk_25m);
      chk("blink_phase", int'(led_a[2]), int'(((edges - 1) >> 3) & 1));
    end

    // Out-of-range addresses are ignored
    for (int ch = 0; ch < 4; ch++) cfg_write(1'b0, 4'(ch), 3'd0, 5'd0, 8'd0);
    cfg_write(1'b0, 4'd7, 3'd1, 5'd0, 8'd0);
    cfg_write(1'b0, 4'd4, 3'd1, 5'd0, 8'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_25m);
      chk("bad_addr", int'(led_a), 0);
    end

    // Wrap tick on the 5-bit counter: high when cnt==1 after a wrap
    pulses = 0;
    for (int k = 0; k < 128; k++) begin
      @(negedge clk_25m);
      pulses += int'(hb_b);
      chk("hb_phase", int'(hb_b), int'((edges % 32 == 1) && (edges > 32)));
    end
    chk("hb_count", pulses, 4);

    // Breathe ramp with mid-ramp rewrite landing on a step cycle
    cfg_write(1'b1, 4'd0, 3'd5, 5'd0, 8'd0);
    bd = 0;
    up = 1'b1;
    rewritten = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      cfg_we_b = 1'b0;
      if (bq.size() > 0) chk("breathe", int'(led_b[0]), int'(bq.pop_front()));
      c = edges % 16;
      bq.push_back(c < 32'(bd));
      if (!rewritten && k >= 600 && c == 0) begin
        rewritten = 1'b1;
        cfg_addr  = 4'd0;
        cfg_wdata = {16'h0, 8'd0, 5'd0, 3'd5};
        cfg_we_b  = 1'b1;
        bd = 0;
        up = 1'b1;
      end else if (c == 0) begin
        if (up) begin
          bd++;
          if (bd == 15) up = 1'b0;
        end else begin
          bd--;
          if (bd == 0) up = 1'b1;
        end
      end
      @(negedge clk_25m);
    end
    cfg_we_b = 1'b0;
    bq.delete();

    // Asynchronous reset mid-PWM
    cfg_write(1'b0, 4'd1, 3'd1, 5'd0, 8'd0);
    cfg_write(1'b0, 4'd0, 3'd3, 5'd0, 8'd128);
    hi = 0;
    for (int k = 0; k < 300 && hi == 0; k++) begin
      @(negedge clk_25m);
      hi = int'(led_a[0]);
    end
    chk("pwm_high_seen", hi, 1);
    chk("pre_rst_on", int'(led_a[1]), 1);
    #2;
    sys_rstn = 1'b0;
    #1;
    chk("async_rst_led_a", int'(led_a), 0);
    chk("async_rst_led_b", int'(led_b), 0);
    chk("async_rst_hb_a", int'(hb_a), 0);
    @(negedge clk_25m);
    @(negedge clk_25m);
    sys_rstn  = 1'b1;
    gpio_oe_n = 4'h0;
    gpio_out  = 4'b1010;
    @(negedge clk_25m);
    @(negedge clk_25m);
    chk("post_rst_gpio_a", int'(led_a), 10);
    chk("post_rst_gpio_b", int'(led_b), 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
